reduce_minmax: RTL
==================

# reduce_minmax

Streaming min/max reduction stage that consumes a burst of operands from the PE datapath and returns the extreme value and the index of its first occurrence. Sits directly downstream of the PE operand path and instantiates `comparator` to decide, for each accepted beat, whether the new operand replaces the running best. It is used for max/min pooling and argmax over a vector before results are written back.

## Interface
- `DATA_WIDTH`, 8, operand width
- `INDEX_WIDTH`, 8, element-count and index width; max burst is 2^INDEX_WIDTH elements

- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a burst; honoured only in IDLE
- `cfg_mode`  in  1  0 = max, 1 = min; sampled on accepted `start`
- `cfg_len`  in  INDEX_WIDTH  burst length minus one; sampled on accepted `start`
- `busy`  out  1  high in ACCUM and DONE
- `in_valid`  in  1  operand valid
- `in_ready`  out  1  operand accepted when `in_valid && in_ready`
- `in_data`  in  DATA_WIDTH  operand
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out_data`  out  DATA_WIDTH  extreme value
- `out_index`  out  INDEX_WIDTH  position (0-based) of first occurrence of the extreme value

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. `start`=1 → latch `cfg_mode`, `cfg_len`; clear `count`; go to ACCUM.
- ACCUM: `in_ready`=1. On accepted beat:
  - `count`==0: `best`←`in_data`, `best_idx`←0 unconditionally.
  - otherwise: replace `best`/`best_idx` only if `in_data` > `best` (max) or `in_data` < `best` (min), using the comparator's `greater`/`lower` with a=`in_data`, b=`best`. Equal never replaces (first occurrence wins).
  - `count`==`cfg_len` on the accepted beat → go to DONE; else `count`+1.
- DONE: `out_valid`=1, `out_data`=`best`, `out_index`=`best_idx`, held stable until `out_ready`; handshake → IDLE.
- `start` outside IDLE is ignored (no queueing).
- `cfg_len`=0: single-beat burst, result is that operand, index 0.
- `cfg_len`=2^INDEX_WIDTH−1: `count` reaches all-ones without wrap; terminal detection is by equality, never by overflow.
- `in_valid` low in ACCUM: stall, no state change.
- Reset mid-burst: all state cleared, partial result discarded.

## Timing
- Reset values: `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_index`=0; state IDLE, `count`=0.
- `start` in cycle T → `in_ready`=1 in T+1.
- Throughput: one operand per cycle in ACCUM.
- Last beat accepted in cycle T → `out_valid`=1 in T+1 (latency 1 from last beat).
- `out_ready` already high when `out_valid` rises → result consumed that cycle, IDLE in next; new `start` accepted from that IDLE cycle.
- All outputs registered or decoded from state only; no combinational path from `in_valid`/`out_ready` to any output.

## Configuration
- `REDUCE_SIGNED_EN` defined: operands are two's-complement; MSB of both comparator inputs is inverted before comparison so the unsigned comparator yields signed order.
- Not defined: operands are unsigned; comparator inputs are passed unmodified.
- `out_data` always carries the original, unmodified operand bits.

## Structure
- Shared package: FSM state encoding (`RMM_IDLE`, `RMM_ACCUM`, `RMM_DONE`) and mode constants (`RMM_MODE_MAX`=0, `RMM_MODE_MIN`=1).
- One sub-module: `comparator` (DATA_WIDTH parameter passed through), instanced once, purely combinational.

## Test plan
- Max, unsigned, `cfg_len`=3, stream 5,9,2,9 → `out_data`=9, `out_index`=1 (tie keeps first).
- Min, unsigned, `cfg_len`=4, stream 7,3,8,3,1 with `in_valid` gaps between beats → `out_data`=1, `out_index`=4, `out_valid` exactly one cycle after the last beat.
- `cfg_len`=0, stream 0x42 → `out_data`=0x42, `out_index`=0; `out_ready` held low 5 cycles → outputs stable, `start` pulses ignored.
- With `REDUCE_SIGNED_EN`, max, stream 0x80,0x7F,0xFF → `out_data`=0x7F, `out_index`=1; without the macro → `out_data`=0xFF, `out_index`=2.
- `cfg_len`=255, stream ramp 0..255, max → `out_index`=255, no early termination or wrap.
- Deassert `reset_n` after 2 of 4 beats → all outputs 0, IDLE; fresh burst after release gives a correct result.

Source files
------------

// File: rtl/reduce_minmax_pkg.sv
// Shared definitions for the reduce_minmax streaming min/max reduction stage:
// FSM state encoding and reduction mode constants.
package reduce_minmax_pkg;

  typedef enum logic [1:0] {
    RMM_IDLE  = 2'd0,
    RMM_ACCUM = 2'd1,
    RMM_DONE  = 2'd2
  } rmm_state_e;

  localparam logic RMM_MODE_MAX = 1'b0;
  localparam logic RMM_MODE_MIN = 1'b1;

endpackage

// File: rtl/reduce_minmax_if.sv
// Handshake bundle for reduce_minmax: burst control, operand stream and result.
// The master side drives requests and operands; the slave side is the reducer.
interface reduce_minmax_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 8
);
  logic                   start;
  logic                   cfg_mode;
  logic [INDEX_WIDTH-1:0] cfg_len;
  logic                   busy;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [INDEX_WIDTH-1:0] out_index;

  modport master (
    output start, cfg_mode, cfg_len, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, out_data, out_index
  );

  modport slave (
    input  start, cfg_mode, cfg_len, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/reduce_minmax_comparator.sv
// Purely combinational unsigned magnitude comparator used by reduce_minmax
// to decide whether a new operand replaces the running best.
module comparator #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  greater,
  output logic                  lower
);

  assign greater = (a > b);
  assign lower   = (a < b);

endmodule

// File: rtl/reduce_minmax.sv
// Streaming min/max reduction returning the extreme value and the index of its
// first occurrence. Define REDUCE_SIGNED_EN for two's-complement operand ordering.
module reduce_minmax
  import reduce_minmax_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  reduce_minmax_if.slave bus
);

  rmm_state_e             state_q, state_d;
  logic                   mode_q, mode_d;
  logic [INDEX_WIDTH-1:0] len_q, len_d;
  logic [INDEX_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0]  best_q, best_d;
  logic [INDEX_WIDTH-1:0] best_idx_q, best_idx_d;

  logic [DATA_WIDTH-1:0]  cmp_a, cmp_b;
  logic                   cmp_greater, cmp_lower;
  logic                   replace;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  function automatic logic [DATA_WIDTH-1:0] cmp_key(input logic [DATA_WIDTH-1:0] x);
`ifdef REDUCE_SIGNED_EN
    return {~x[DATA_WIDTH-1], x[DATA_WIDTH-2:0]};
`else
    return x;
`endif
  endfunction

  assign cmp_a = cmp_key(bus.in_data);
  assign cmp_b = cmp_key(best_q);

  comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .a       (cmp_a),
    .b       (cmp_b),
    .greater (cmp_greater),
    .lower   (cmp_lower)
  );

  // Strict comparison only: ties keep the earlier index.
  assign replace = (mode_q == RMM_MODE_MIN) ? cmp_lower : cmp_greater;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    count_d    = count_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    case (state_q)
      RMM_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.cfg_mode;
          len_d   = bus.cfg_len;
          count_d = '0;
          state_d = RMM_ACCUM;
        end
      end
      RMM_ACCUM: begin
        if (bus.in_valid) begin
          if ((count_q == '0) || replace) begin
            best_d     = bus.in_data;
            best_idx_d = count_q;
          end
          // Terminal detection by equality so a full 2^INDEX_WIDTH burst never wraps.
          if (count_q == len_q) begin
            state_d = RMM_DONE;
          end else begin
            count_d = count_q + INDEX_WIDTH'(1);
          end
        end
      end
      RMM_DONE: begin
        if (bus.out_ready) begin
          state_d = RMM_IDLE;
        end
      end
      default: state_d = RMM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RMM_IDLE;
      mode_q     <= RMM_MODE_MAX;
      len_q      <= '0;
      count_q    <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      count_q    <= count_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  // Outputs decode from state or come straight from flops.
  assign bus.busy      = (state_q != RMM_IDLE);
  assign bus.in_ready  = (state_q == RMM_ACCUM);
  assign bus.out_valid = (state_q == RMM_DONE);
  assign bus.out_data  = best_q;
  assign bus.out_index = best_idx_q;

endmodule
